// File: rtl/sw_debouncer_array.sv
// N-channel switch debouncer producing a filtered level, rise/fall strobes and an aggregate change flag.
// Define SW_DEBOUNCER_SYNC_EN to put a 2-flop synchroniser in front of each channel's filter.
module sw_debouncer_array #(
  parameter int unsigned N             = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned CW            = $clog2(STABLE_CYCLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] PB,
  output logic [N-1:0] DEBOUNCED,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL,
  output logic         CHANGED
);

  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [N-1:0] x;

`ifdef SW_DEBOUNCER_SYNC_EN
  logic [N-1:0] sync1_q, sync1_d;
  logic [N-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = PB;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign x = sync2_q;
`else
  assign x = PB;
`endif

  logic [N-1:0]  db_q, db_d;
  logic [N-1:0]  rise_q, rise_d;
  logic [N-1:0]  fall_q, fall_d;
  logic          changed_q, changed_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];

  // Per channel: any sample matching the current level restarts the window, discarding bounces.
  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      cnt_d[i] = cnt_q[i];
      if (x[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]   = x[i];
        cnt_d[i]  = '0;
        rise_d[i] = x[i];
        fall_d[i] = ~x[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_q      <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q      <= db_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign DEBOUNCED = db_q;
  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign CHANGED   = changed_q;

endmodule

// File: doc/sw_debouncer_array.md
# sw_debouncer_array

Parametrised multi-channel successor to the single-switch debouncer. It filters N raw push-button/switch inputs with a configurable stability window and produces a clean level per channel. It also produces one-cycle rise and fall strobes per channel, plus an aggregate change flag. It sits between board-level pins and the fault-injection/control logic, which consumes the strobes directly instead of building its own edge detectors.

## Interface
Parameters:
- `N`, 4: number of independent channels (1..32).
- `STABLE_CYCLES`, 16: consecutive clock cycles a differing input must hold before the output follows (min 2).
- `CW`, `$clog2(STABLE_CYCLES)`: counter width. Derived; not overridden.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `PB`, in, N: raw, bouncy switch inputs, one bit per channel.
- `DEBOUNCED`, out, N: filtered level per channel.
- `RISE`, out, N: one-cycle strobe when `DEBOUNCED[i]` goes 0→1.
- `FALL`, out, N: one-cycle strobe when `DEBOUNCED[i]` goes 1→0.
- `CHANGED`, out, 1: OR-reduction of `RISE | FALL`, registered in the same cycle as the strobes.

## Operation
- Each channel is independent. It has a filter input `x[i]`, a counter `cnt[i]` (CW bits) and a state bit `db[i]` that drives `DEBOUNCED[i]`.
- `x[i]` is `PB[i]` directly, or its synchronised copy (see Configuration).
- Per-channel states, encoded by `db` and `cnt`:
  - STABLE_LO: `db=0`, `cnt=0`.
  - CHECK_HI: `db=0`, `cnt>0`.
  - STABLE_HI: `db=1`, `cnt=0`.
  - CHECK_LO: `db=1`, `cnt>0`.
- Each rising edge:
  - If `x==db`: `cnt<=0`. The channel returns to the STABLE state, which is how bounces are discarded.
  - If `x!=db` and `cnt==STABLE_CYCLES-1`: `db<=x`, `cnt<=0`, and the matching `RISE`/`FALL` bit goes high for this cycle only.
  - If `x!=db` otherwise: `cnt<=cnt+1`.
- `cnt` never exceeds `STABLE_CYCLES-1`, so no wrap-around is possible.
- Strobes are high for exactly one cycle per transition. `RISE[i]` and `FALL[i]` are never high together.
- `CHANGED` is high in any cycle where at least one channel strobes. Simultaneous transitions on several channels produce a single `CHANGED` cycle.

## Timing
- Reset values: `DEBOUNCED=0`, `RISE=0`, `FALL=0`, `CHANGED=0`. All `cnt=0`; synchroniser flops are 0.
- Latency without sync, from the first rising edge that samples a new stable `PB` value:
  - `DEBOUNCED` updates on the `STABLE_CYCLES`-th edge, counting that first edge as edge 1.
  - Strobes assert on the same edge as the `DEBOUNCED` update.
- With sync, latency is `STABLE_CYCLES+2` edges.
- Glitch rejection:
  - A pulse of `STABLE_CYCLES-1` cycles or shorter never changes the output.
  - A pulse of exactly `STABLE_CYCLES` cycles changes the output.
- Reset asserted mid-count or mid-strobe: on the next edge all state is cleared, and any pending strobe is dropped.
- If `PB=1` is held through reset release, the output rises only after a full window (plus sync delay) counted from the first post-reset edge.
- `rst` has priority over all other updates.

## Configuration
- Macro: `SW_DEBOUNCER_SYNC_EN`.
- Defined:
  - Each `PB[i]` passes through a 2-flop synchroniser (reset to 0) before the filter.
  - Adds 2 cycles of latency.
  - Required when `PB` comes from asynchronous pins.
- Undefined:
  - `x = PB` directly, and latency is exactly `STABLE_CYCLES`.
  - Used when `PB` is already synchronous to `clk`, e.g. driven by the fault injector.

## Test plan
All scenarios use `N=4`, `STABLE_CYCLES=4`, macro undefined, and stimulus changes on `negedge clk`, unless stated otherwise.
- Reset: `rst=1` for 2 cycles with `PB=4'hF` → all outputs 0 during reset. After release, `DEBOUNCED=4'hF` at post-reset edge 4, with `RISE=4'hF` and `CHANGED=1` for that single cycle.
- Glitch reject: `PB[0]=1` for 3 cycles, then 0 → `DEBOUNCED[0]`, `RISE[0]` and `CHANGED` stay 0 throughout.
- Bounce then settle: `PB[1]` toggles 1,0,1,0,1 on consecutive cycles, then holds 1 → `DEBOUNCED[1]=1` exactly 4 edges after the final 0→1; one `RISE[1]` pulse only.
- Fall and independence: with `DEBOUNCED=4'b0110`, drop `PB[2]` and raise `PB[3]` on the same cycle → after 4 edges `DEBOUNCED=4'b1010`, `FALL=4'b0100`, `RISE=4'b1000`, and `CHANGED` is high for exactly one cycle.
- Reset mid-count: `PB[0]=1` for 2 cycles, then `rst=1` for 1 cycle with `PB` held at 1 → `cnt` is cleared. `DEBOUNCED[0]` rises at post-reset edge 4, not edge 2.
- Sync build: define `SW_DEBOUNCER_SYNC_EN` and repeat the reset scenario → `DEBOUNCED` rises at post-reset edge 6.
